// File: rtl/mem_order_queue.sv
// mem_order_queue: load/store ordering queue between dispatch and the data-memory port.
// Store-to-load forwarding (fwd_* outputs) is compiled in only when MOQ_FWD_EN is defined.
module mem_order_queue #(
  parameter int SB_DEPTH = 8,
  parameter int LB_DEPTH = 8,
  parameter int ROB_AW   = 5,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_is_store,
  input  logic [ROB_AW-1:0]             in_rob,
  input  logic [ADDR_W-1:0]             in_addr,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [ROB_AW-1:0]             rob_head,
  input  logic                          flush,
  output logic                          req_valid,
  input  logic                          req_ready,
  output logic                          req_is_store,
  output logic [ROB_AW-1:0]             req_rob,
  output logic [ADDR_W-1:0]             req_addr,
  output logic [DATA_W-1:0]             req_data,
  output logic [$clog2(SB_DEPTH+1)-1:0] sb_count,
  output logic [$clog2(LB_DEPTH+1)-1:0] lb_count
`ifdef MOQ_FWD_EN
  ,
  output logic                          fwd_valid,
  output logic [ROB_AW-1:0]             fwd_rob,
  output logic [DATA_W-1:0]             fwd_data
`endif
);

  localparam int SPW = $clog2(SB_DEPTH);
  localparam int LIW = $clog2(LB_DEPTH);
  localparam int SCW = $clog2(SB_DEPTH+1);
  localparam int LCW = $clog2(LB_DEPTH+1);

  // Distance from the ROB head; wraps so that the oldest in-flight entry is always 0.
  function automatic logic [ROB_AW-1:0] age_of(input logic [ROB_AW-1:0] rob,
                                               input logic [ROB_AW-1:0] head);
    return rob - head;
  endfunction

  logic [SB_DEPTH-1:0] sb_valid;
  logic [ROB_AW-1:0]   sb_rob  [SB_DEPTH];
  logic [ADDR_W-1:0]   sb_addr [SB_DEPTH];
  logic [DATA_W-1:0]   sb_data [SB_DEPTH];
  logic [SPW-1:0]      sb_head;
  logic [SPW-1:0]      sb_tail;

  logic [LB_DEPTH-1:0] lb_valid;
  logic [ROB_AW-1:0]   lb_rob  [LB_DEPTH];
  logic [ADDR_W-1:0]   lb_addr [LB_DEPTH];

  logic                sb_full;
  logic                lb_full;
  logic                sb_push;
  logic                lb_push;
  logic                sb_pop;
  logic                lb_pop;
  logic [LIW-1:0]      lb_free_idx;

  logic                st_ok;
  logic [ROB_AW-1:0]   st_age;
  logic                ld_ok;
  logic [LIW-1:0]      ld_sel;
  logic [ROB_AW-1:0]   ld_age;
  logic                pick_store;
  logic                pick_load;

  logic                fwd_fire;
  logic [LIW-1:0]      fwd_idx;

  assign sb_full  = (sb_count == SCW'(SB_DEPTH));
  assign lb_full  = (lb_count == LCW'(LB_DEPTH));
  assign in_ready = in_is_store ? !sb_full : !lb_full;

  assign sb_push = in_valid && in_ready && in_is_store && !flush;
  assign lb_push = in_valid && in_ready && !in_is_store && !flush;

  // Lowest-numbered free load slot; only meaningful when the load buffer is not full.
  always_comb begin
    lb_free_idx = '0;
    for (int i = LB_DEPTH - 1; i >= 0; i--) begin
      if (!lb_valid[i]) lb_free_idx = LIW'(i);
    end
  end

  // Stores leave strictly in program order, so the FIFO head is also the oldest store.
  assign st_age = age_of(sb_rob[sb_head], rob_head);
  assign st_ok  = sb_valid[sb_head] && (sb_rob[sb_head] == rob_head);

  always_comb begin
    ld_ok  = 1'b0;
    ld_sel = '0;
    ld_age = '0;
    for (int i = 0; i < LB_DEPTH; i++) begin
      if (lb_valid[i] &&
          (!sb_valid[sb_head] || age_of(lb_rob[i], rob_head) < st_age) &&
          (!ld_ok || age_of(lb_rob[i], rob_head) < ld_age)) begin
        ld_ok  = 1'b1;
        ld_sel = LIW'(i);
        ld_age = age_of(lb_rob[i], rob_head);
      end
    end
  end

  assign pick_store = st_ok && (!ld_ok || st_age < ld_age);
  assign pick_load  = ld_ok && !pick_store;

  always_comb begin
    req_valid    = st_ok || ld_ok;
    req_is_store = 1'b0;
    req_rob      = '0;
    req_addr     = '0;
    req_data     = '0;
    if (pick_store) begin
      req_is_store = 1'b1;
      req_rob      = sb_rob[sb_head];
      req_addr     = sb_addr[sb_head];
      req_data     = sb_data[sb_head];
    end else if (pick_load) begin
      req_rob      = lb_rob[ld_sel];
      req_addr     = lb_addr[ld_sel];
    end
  end

  assign sb_pop = req_valid && req_ready && pick_store;
  assign lb_pop = req_valid && req_ready && pick_load;

`ifdef MOQ_FWD_EN
  logic [LB_DEPTH-1:0] fwd_cand;
  logic [DATA_W-1:0]   fwd_cand_data [LB_DEPTH];
  logic [LB_DEPTH-1:0] ys_found;
  logic [ROB_AW-1:0]   ys_age [LB_DEPTH];
  logic [ROB_AW-1:0]   fwd_age;

  // For each load find its youngest older store; a matching address makes it forwardable.
  always_comb begin
    for (int i = 0; i < LB_DEPTH; i++) begin
      fwd_cand[i]      = 1'b0;
      fwd_cand_data[i] = '0;
      ys_found[i]      = 1'b0;
      ys_age[i]        = '0;
      for (int j = 0; j < SB_DEPTH; j++) begin
        if (sb_valid[j] &&
            age_of(sb_rob[j], rob_head) < age_of(lb_rob[i], rob_head) &&
            (!ys_found[i] || age_of(sb_rob[j], rob_head) > ys_age[i])) begin
          ys_found[i]      = 1'b1;
          ys_age[i]        = age_of(sb_rob[j], rob_head);
          fwd_cand[i]      = lb_valid[i] && (sb_addr[j] == lb_addr[i]);
          fwd_cand_data[i] = sb_data[j];
        end
      end
    end
  end

  // A forwardable load always has an older store, so it can never be the memory-issued load.
  always_comb begin
    fwd_fire = 1'b0;
    fwd_idx  = '0;
    fwd_age  = '0;
    for (int i = 0; i < LB_DEPTH; i++) begin
      if (fwd_cand[i] && (!fwd_fire || age_of(lb_rob[i], rob_head) < fwd_age)) begin
        fwd_fire = 1'b1;
        fwd_idx  = LIW'(i);
        fwd_age  = age_of(lb_rob[i], rob_head);
      end
    end
  end

  assign fwd_valid = fwd_fire;
  assign fwd_rob   = fwd_fire ? lb_rob[fwd_idx] : '0;
  assign fwd_data  = fwd_fire ? fwd_cand_data[fwd_idx] : '0;
`else
  assign fwd_fire = 1'b0;
  assign fwd_idx  = '0;
`endif

  // Occupancy state; flush behaves like reset but still lets a same-cycle handshake go out.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sb_valid <= '0;
      lb_valid <= '0;
      sb_head  <= '0;
      sb_tail  <= '0;
      sb_count <= '0;
      lb_count <= '0;
    end else if (flush) begin
      sb_valid <= '0;
      lb_valid <= '0;
      sb_head  <= '0;
      sb_tail  <= '0;
      sb_count <= '0;
      lb_count <= '0;
    end else begin
      if (sb_pop) begin
        sb_valid[sb_head] <= 1'b0;
        sb_head           <= sb_head + SPW'(1);
      end
      if (sb_push) begin
        sb_valid[sb_tail] <= 1'b1;
        sb_tail           <= sb_tail + SPW'(1);
      end
      if (lb_pop)   lb_valid[ld_sel]      <= 1'b0;
      if (fwd_fire) lb_valid[fwd_idx]     <= 1'b0;
      if (lb_push)  lb_valid[lb_free_idx] <= 1'b1;
      sb_count <= sb_count + SCW'(sb_push) - SCW'(sb_pop);
      lb_count <= lb_count + LCW'(lb_push) - LCW'(lb_pop) - LCW'(fwd_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (sb_push) begin
      sb_rob[sb_tail]  <= in_rob;
      sb_addr[sb_tail] <= in_addr;
      sb_data[sb_tail] <= in_data;
    end
    if (lb_push) begin
      lb_rob[lb_free_idx]  <= in_rob;
      lb_addr[lb_free_idx] <= in_addr;
    end
  end

endmodule
